kmeans_update_k3_d5: RTL and testbench
======================================

// Module: kmeans_update_k3_d5
// PURPOSE
//  Downstream of the k=3/d=5 distance/assign pipeline. Accumulates the per-centroid
//  per-dimension sums and per-centroid sample counts of classified points. On flush
//  (end of epoch), computes new centroids = sum/count with one shared sequential
//  restoring divider, presents them, then clears the accumulators for the next epoch.
// PARAMETERS
//  input_data_width  16  width of one coordinate (unsigned)
//  count_width       16  width of per-centroid sample counter
//  (derived) sum_width = input_data_width + count_width
// PORTS
//  clk                  in   1      clock, all logic on posedge
//  rst                  in   1      synchronous active-high reset
//  in_valid             in   1      classified point present (upstream valid, delayed to match pipe latency)
//  in_ready             out  1      1 when accepting points (state ACCUM)
//  input_data0..4       in   W each point coordinates d0..d4 (W = input_data_width)
//  selected_centroid    in   2      winning centroid index, 0..2 legal
//  flush                in   1      end of epoch; start centroid recompute
//  new_centroids        out  15*W   k-major: [(k*5+d)*W +: W] = centroid k, dim d
//  update_valid         out  1      1-cycle pulse when new_centroids updated
//  busy                 out  1      1 in DIVIDE or DONE
// BEHAVIOUR
//  Reset: state=ACCUM, all sums/counts=0, new_centroids=0, update_valid=0, busy=0, in_ready=1.
//  States: ACCUM -> DIVIDE (on flush) -> DONE (after last element) -> ACCUM (next cycle).
//  ACCUM: point accepted when in_valid && in_ready. sum[k][d] += input_data_d, count[k] += 1,
//   k = selected_centroid. selected_centroid==3: point dropped, no state change.
//  Count saturation: if count[k] == 2^count_width-1, further points for k are dropped
//   (sum and count both untouched); sum_width guarantees sums never overflow.
//  flush in ACCUM: a point with in_valid in the same cycle is accumulated first, then
//   DIVIDE starts next cycle. flush outside ACCUM ignored.
//  in_valid while in_ready=0: point dropped, no side effect.
//  DIVIDE: elements processed in order k0d0..k0d4, k1d0..k2d4 (15 total), each taking
//   exactly sum_width+1 cycles (1 load + sum_width restoring iterations, MSB-first).
//   Quotient = floor(sum/count), truncated to W bits (always fits since mean <= max input).
//   count[k]==0: same cycle budget used; result for k keeps its previous value.
//   Each result is written into an internal shadow register; new_centroids unchanged
//   during DIVIDE.
//  DONE (1 cycle): new_centroids <= shadow, update_valid=1, sums/counts cleared.
//  Latency: flush accepted at cycle T -> update_valid at T+1+15*(sum_width+1)
//   (T+496 with defaults); in_ready=1 again at T+497.
//  rst mid-DIVIDE/DONE: immediate return to reset state, partial results discarded.
//  update_valid never asserted twice without an intervening flush.
// TESTING
//  1 rst; 4 points k=0 with d0=10,20,30,40 (others 0); flush -> update_valid at T+496,
//    new_centroids k0d0=25, k0d1..4=0.
//  2 k=1 points d0=1,2 -> k1d0=1 (truncation); k=2 no points -> k2 all dims stay 0
//    after reset, stay at epoch-1 values in second epoch.
//  3 flush with in_valid same cycle (k=0,d0=100, only point) -> k0d0=100.
//  4 in_valid during DIVIDE (k=0,d0=9999) -> in_ready=0, next epoch result unaffected.
//  5 selected_centroid=3 with d0=500 mixed with k=0 d0=4 -> k0d0=4, no effect from idx 3.
//  6 rst asserted at T+200 in DIVIDE -> next cycle in_ready=1, new_centroids=0,
//    no update_valid; fresh epoch then computes correctly.

Source files
------------

// File: rtl/kmeans_update_k3_d5.sv
// k-means centroid update for k=3, d=5: per-epoch sum/count accumulation, then
// sequential restoring division of all 15 sums into a shadow bank presented on DONE.
module kmeans_update_k3_d5 #(
  parameter int unsigned input_data_width = 16,
  parameter int unsigned count_width      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [input_data_width-1:0]     input_data0,
  input  logic [input_data_width-1:0]     input_data1,
  input  logic [input_data_width-1:0]     input_data2,
  input  logic [input_data_width-1:0]     input_data3,
  input  logic [input_data_width-1:0]     input_data4,
  input  logic [1:0]                      selected_centroid,
  input  logic                            flush,
  output logic [15*input_data_width-1:0]  new_centroids,
  output logic                            update_valid,
  output logic                            busy
);

  localparam int unsigned sum_width = input_data_width + count_width;
  localparam int unsigned iter_w    = $clog2(sum_width + 1);
  localparam int unsigned num_k     = 3;
  localparam int unsigned num_d     = 5;

  localparam logic [1:0] StAccum  = 2'd0;
  localparam logic [1:0] StDivide = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]                  state_q;
  logic [sum_width-1:0]        sum_q    [num_k][num_d];
  logic [count_width-1:0]      count_q  [num_k];
  logic [input_data_width-1:0] shadow_q [num_k][num_d];
  logic [input_data_width-1:0] cent_q   [num_k][num_d];

  logic [1:0]                  k_q;
  logic [2:0]                  d_q;
  logic [iter_w-1:0]           iter_q;
  logic [count_width-1:0]      rem_q;
  logic [sum_width-1:0]        dq_q;

  logic [input_data_width-1:0] in_data [num_d];
  logic [1:0]                  sel_idx;
  logic                        accept;

  logic [count_width-1:0]      div_count;
  logic [sum_width-1:0]        div_sum;
  logic [count_width:0]        trial;
  logic                        ge;
  logic [count_width-1:0]      rem_n;
  logic [sum_width-1:0]        dq_n;
  logic                        last_iter;

  assign in_data[0] = input_data0;
  assign in_data[1] = input_data1;
  assign in_data[2] = input_data2;
  assign in_data[3] = input_data3;
  assign in_data[4] = input_data4;

  assign in_ready     = (state_q == StAccum);
  assign busy         = (state_q == StDivide) || (state_q == StDone);
  assign update_valid = (state_q == StDone);

  // Index 3 is illegal; alias it to 0 so the saturation lookup never goes out of range.
  assign sel_idx = (selected_centroid == 2'd3) ? 2'd0 : selected_centroid;
  assign accept  = in_valid && in_ready && (selected_centroid != 2'd3) &&
                   (count_q[sel_idx] != {count_width{1'b1}});

  assign div_count = count_q[k_q];
  assign div_sum   = sum_q[k_q][d_q];
  assign last_iter = (iter_q == iter_w'(sum_width));

  // One restoring step: the partial remainder is always below the divisor, so the
  // subtraction can be done modulo 2^count_width.
  always_comb begin
    trial = {rem_q, dq_q[sum_width-1]};
    ge    = (trial >= {1'b0, div_count});
    rem_n = ge ? (trial[count_width-1:0] - div_count) : trial[count_width-1:0];
    dq_n  = {dq_q[sum_width-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
      k_q     <= '0;
      d_q     <= '0;
      iter_q  <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      for (int k = 0; k < num_k; k++) begin
        count_q[k] <= '0;
        for (int d = 0; d < num_d; d++) begin
          sum_q[k][d]    <= '0;
          shadow_q[k][d] <= '0;
          cent_q[k][d]   <= '0;
        end
      end
    end else begin
      case (state_q)
        StAccum: begin
          if (accept) begin
            count_q[sel_idx] <= count_q[sel_idx] + 1'b1;
            for (int d = 0; d < num_d; d++) begin
              sum_q[sel_idx][d] <= sum_q[sel_idx][d] + sum_width'(in_data[d]);
            end
          end
          if (flush) begin
            state_q <= StDivide;
            k_q     <= '0;
            d_q     <= '0;
            iter_q  <= '0;
          end
        end

        StDivide: begin
          if (iter_q == '0) begin
            rem_q  <= '0;
            dq_q   <= div_sum;
            iter_q <= iter_w'(1);
          end else begin
            rem_q <= rem_n;
            dq_q  <= dq_n;
            if (last_iter) begin
              iter_q <= '0;
              // Empty cluster: keep the previous centroid.
              if (div_count != '0) begin
                shadow_q[k_q][d_q] <= dq_n[input_data_width-1:0];
              end
              if (d_q == 3'd4) begin
                d_q <= '0;
                if (k_q == 2'd2) begin
                  state_q <= StDone;
                end else begin
                  k_q <= k_q + 2'd1;
                end
              end else begin
                d_q <= d_q + 3'd1;
              end
            end else begin
              iter_q <= iter_q + iter_w'(1);
            end
          end
        end

        StDone: begin
          state_q <= StAccum;
          for (int k = 0; k < num_k; k++) begin
            count_q[k] <= '0;
            for (int d = 0; d < num_d; d++) begin
              sum_q[k][d]  <= '0;
              cent_q[k][d] <= shadow_q[k][d];
            end
          end
        end

        default: state_q <= StAccum;
      endcase
    end
  end

  // Shadow bank is exposed during DONE so the outputs and update_valid coincide.
  for (genvar k = 0; k < num_k; k++) begin : g_out_k
    for (genvar d = 0; d < num_d; d++) begin : g_out_d
      assign new_centroids[(k*num_d+d)*input_data_width +: input_data_width] =
        (state_q == StDone) ? shadow_q[k][d] : cent_q[k][d];
    end
  end

endmodule

// File: tb/tb_kmeans_update_k3_d5.sv
// Randomized bench for kmeans_update_k3_d5: a mean-of-points model feeds a scoreboard
// queue that a negedge monitor drains whenever update_valid is seen.
module tb_kmeans_update_k3_d5;

  localparam int W       = 16;
  localparam int LATENCY = 496;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    din [5];
  logic [1:0]      sel;
  logic            flush;
  logic [15*W-1:0] nc;
  logic            update_valid;
  logic            busy;

  kmeans_update_k3_d5 dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .input_data0       (din[0]),
    .input_data1       (din[1]),
    .input_data2       (din[2]),
    .input_data3       (din[3]),
    .input_data4       (din[4]),
    .selected_centroid (sel),
    .flush             (flush),
    .new_centroids     (nc),
    .update_valid      (update_valid),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int              due;
    logic [15*W-1:0] vec;
  } exp_t;

  exp_t            sbq[$];
  longint unsigned m_sum [3][5];
  int unsigned     m_cnt [3];
  logic [W-1:0]    m_cent [3][5];
  bit              m_accum;
  int              t_flush;
  int              errors = 0;
  int              checks = 0;

  task automatic check(input string name, input logic [15*W-1:0] act,
                       input logic [15*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      for (int d = 0; d < 5; d++) begin
        m_sum[k][d]  = 0;
        m_cent[k][d] = '0;
      end
    end
    m_accum = 1'b1;
    sbq.delete();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    sel      = 2'd0;
    for (int d = 0; d < 5; d++) din[d] = '0;
  endtask

  // Drive one cycle of stimulus and update the model with what the DUT should do.
  task automatic drive(input bit v, input int k, input int a0, input int a1, input int a2,
                       input int a3, input int a4, input bit f);
    exp_t e;
    in_valid = v;
    sel      = 2'(k);
    din[0] = W'(a0); din[1] = W'(a1); din[2] = W'(a2); din[3] = W'(a3); din[4] = W'(a4);
    flush    = f;
    if (v && m_accum && k < 3) begin
      m_cnt[k]++;
      for (int d = 0; d < 5; d++) m_sum[k][d] += longint'(din[d]);
    end
    if (f && m_accum) begin
      e.vec = '0;
      for (int kk = 0; kk < 3; kk++) begin
        for (int d = 0; d < 5; d++) begin
          if (m_cnt[kk] != 0) m_cent[kk][d] = W'(m_sum[kk][d] / m_cnt[kk]);
          e.vec[(kk*5+d)*W +: W] = m_cent[kk][d];
          m_sum[kk][d] = 0;
        end
        m_cnt[kk] = 0;
      end
      e.due   = cyc_cnt + LATENCY;
      t_flush = cyc_cnt;
      sbq.push_back(e);
      m_accum = 1'b0;
    end
    tick();
    idle_inputs();
  endtask

  task automatic point0(input int k, input int a0);
    drive(1'b1, k, a0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic wait_update();
    int n = 0;
    while (sbq.size() != 0 && n < 600) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL update_timeout: got no update_valid expected one within 600 cycles");
      sbq.delete();
    end
    check("ready_after_done", 240'(in_ready), 240'(1));
    check("busy_after_done", 240'(busy), 240'(0));
    m_accum = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (!rst && update_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_update: got update_valid=1 expected 0 at cycle %0d", cyc_cnt);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("update_latency", 240'(cyc_cnt), 240'(e.due));
        check("centroids", nc, e.vec);
        check("ready_in_done", 240'(in_ready), 240'(0));
        check("busy_in_done", 240'(busy), 240'(1));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    do_reset();

    check("reset_ready", 240'(in_ready), 240'(1));
    check("reset_busy", 240'(busy), 240'(0));
    check("reset_update_valid", 240'(update_valid), 240'(0));
    check("reset_centroids", nc, '0);

    // 1: mean of four points on k0.
    point0(0, 10); point0(0, 20); point0(0, 30); point0(0, 40);
    do_flush();
    check("busy_in_divide", 240'(busy), 240'(1));
    wait_update();

    // 2: truncation on k1; k0/k2 keep previous values.
    point0(1, 1); point0(1, 2);
    do_flush();
    wait_update();

    // 3: point accepted in the flush cycle.
    drive(1'b1, 0, 100, 0, 0, 0, 0, 1'b1);
    wait_update();

    // 4: point offered during DIVIDE is dropped.
    point0(0, 7);
    do_flush();
    tick();
    check("ready_in_divide", 240'(in_ready), 240'(0));
    point0(0, 9999);
    wait_update();
    point0(0, 3);
    do_flush();
    wait_update();

    // 5: index 3 has no effect.
    point0(3, 500); point0(0, 4); point0(3, 500);
    do_flush();
    wait_update();

    // 6: reset in the middle of DIVIDE.
    point0(2, 1234); point0(1, 55);
    do_flush();
    while (cyc_cnt < t_flush + 200) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midreset_ready", 240'(in_ready), 240'(1));
    check("midreset_busy", 240'(busy), 240'(0));
    check("midreset_centroids", nc, '0);
    for (int i = 0; i < 350; i++) tick();
    point0(2, 600); point0(2, 601);
    drive(1'b1, 1, 17, 18, 19, 20, 21, 1'b0);
    do_flush();
    wait_update();

    // Randomized epochs.
    for (int ep = 0; ep < 6; ep++) begin
      int npts = $urandom_range(1, 25);
      for (int p = 0; p < npts; p++) begin
        bit last = (p == npts - 1) && ($urandom_range(0, 1) == 1);
        drive(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), last);
        if (!last && $urandom_range(0, 3) == 0) tick();
      end
      if (m_accum) do_flush();
      wait_update();
    end

    for (int i = 0; i < 20; i++) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
